dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the pipeline MEM stage (P, primary) and a

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arb_starve_ctr.sv | 39 +++
 rtl/dmem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ARB    = 1'b0,
        D_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_P = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // True when a word address falls inside the populated part of data memory.
    function automatic logic addr_in_range(input logic [DATA_W-1:0] addr,
                                           input logic [DATA_W-1:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating wait counter that tracks how long the debug port has been refused.
// at_max tells the arbiter that the debug port must win the current cycle.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic incr,
    output logic at_max
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_max = (cnt_q == CNT_W'(MAX_WAIT));

    // Next count: clear wins, otherwise count up and stick at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (incr && !at_max) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data memory between the pipeline MEM stage
// (P, primary) and the debug/loader port (D, secondary). Grants and memory
// strobes are combinational; read data, valid and the address error flag are
// registered one cycle after the grant.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration in the ARB
// state; otherwise P has fixed priority and D is protected by a starvation
// counter limited to MAX_WAIT.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [DATA_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_lock,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memwrite,
    output logic              mem_memread,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              err_addr
);

    arb_state_e        state_q, state_d;
    logic              p_gnt_c, d_gnt_c;
    logic              gnt_any;
    logic              sel_we;
    logic [DATA_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_in_range;

    logic              p_rvalid_q, p_rvalid_d;
    logic [DATA_W-1:0] p_rdata_q,  p_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;
    logic              err_addr_q, err_addr_d;

`ifdef DMEM_ARB_RR_EN
    // Round-robin needs to remember who was served last; fixed priority does not.
    req_id_e           last_gnt_q, last_gnt_d;
`else
    logic              starve_at_max;

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (d_gnt_c | ~d_req),
        .incr   (d_req & ~d_gnt_c),
        .at_max (starve_at_max)
    );
`endif

    // Grant decision and next FSM state; nothing is granted while reset is held.
    always_comb begin
        p_gnt_c = 1'b0;
        d_gnt_c = 1'b0;
        state_d = state_q;
        if (rst_n) begin
            case (state_q)
                ARB: begin
`ifdef DMEM_ARB_RR_EN
                    if (p_req && d_req) begin
                        if (last_gnt_q == REQ_P) begin
                            d_gnt_c = 1'b1;
                        end else begin
                            p_gnt_c = 1'b1;
                        end
                    end else begin
                        p_gnt_c = p_req;
                        d_gnt_c = d_req;
                    end
`else
                    if (d_req && starve_at_max) begin
                        d_gnt_c = 1'b1;
                    end else if (p_req) begin
                        p_gnt_c = 1'b1;
                    end else begin
                        d_gnt_c = d_req;
                    end
`endif
                    if (d_gnt_c && d_lock) begin
                        state_d = D_LOCK;
                    end
                end
                D_LOCK: begin
                    d_gnt_c = d_req;
                    if (!d_lock) begin
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    assign p_gnt   = p_gnt_c;
    assign d_gnt   = d_gnt_c;
    assign p_stall = p_req & ~p_gnt_c;
    assign gnt_any = p_gnt_c | d_gnt_c;

    // Steer the granted requester onto the memory bus; out-of-range accesses keep strobes low.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (p_gnt_c) begin
            sel_we    = p_we;
            sel_addr  = p_addr;
            sel_wdata = p_wdata;
        end else if (d_gnt_c) begin
            sel_we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
        sel_in_range   = addr_in_range(sel_addr, DATA_W'(DEPTH));
        mem_addr       = sel_addr;
        mem_write_data = sel_wdata;
        mem_memwrite   = gnt_any & sel_we & sel_in_range;
        mem_memread    = gnt_any & ~sel_we & sel_in_range;
    end

    // Response path: capture read data for whoever was granted a read this cycle.
    always_comb begin
        p_rvalid_d = p_gnt_c & ~p_we;
        d_rvalid_d = d_gnt_c & ~d_we;
        p_rdata_d  = p_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (p_rvalid_d) begin
            p_rdata_d = sel_in_range ? mem_read_data : '0;
        end
        if (d_rvalid_d) begin
            d_rdata_d = sel_in_range ? mem_read_data : '0;
        end
        err_addr_d = gnt_any & ~sel_in_range;
    end

`ifdef DMEM_ARB_RR_EN
    // Remember the most recent winner so the other side gets the next tie.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p_gnt_c) begin
            last_gnt_d = REQ_P;
        end else if (d_gnt_c) begin
            last_gnt_d = REQ_D;
        end
    end

    // Round-robin history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= REQ_P;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // FSM state and registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            p_rvalid_q <= 1'b0;
            p_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            err_addr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            p_rvalid_q <= p_rvalid_d;
            p_rdata_q  <= p_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign p_rvalid = p_rvalid_q;
    assign p_rdata  = p_rdata_q;
    assign d_rvalid = d_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (default fixed-priority build) with a small
// behavioural data memory: writes at posedge, read data updated at negedge.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p_req, p_we, d_req, d_we, d_lock;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
    logic        p_gnt, p_stall, p_rvalid, d_gnt, d_rvalid;
    logic [31:0] p_rdata, d_rdata;
    logic [31:0] mem_addr, mem_write_data, mem_read_data;
    logic        mem_memwrite, mem_memread, err_addr;

    logic [31:0] mem [0:255];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic        p_req, p_we;
        logic [31:0] p_addr, p_wdata;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic        d_lock;
        logic        e_p_gnt, e_d_gnt, e_we, e_re;
        logic [31:0] e_addr, e_wdata;
        logic        e_prv;
        logic [31:0] e_prd;
        logic        e_drv;
        logic [31:0] e_drd;
        logic        e_err;
    } vec_t;

    vec_t vecs [20];

    dmem_arbiter #(
        .DEPTH    (256),
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .p_req          (p_req),
        .p_we           (p_we),
        .p_addr         (p_addr),
        .p_wdata        (p_wdata),
        .p_gnt          (p_gnt),
        .p_stall        (p_stall),
        .p_rvalid       (p_rvalid),
        .p_rdata        (p_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_lock         (d_lock),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_memwrite   (mem_memwrite),
        .mem_memread    (mem_memread),
        .mem_read_data  (mem_read_data),
        .err_addr       (err_addr)
    );

    // Free-running clock, posedges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory write port.
    always @(posedge clk) begin
        if (mem_memwrite) mem[mem_addr[7:0]] <= mem_write_data;
    end

    // Memory read port, updated on the falling edge.
    always @(negedge clk) begin
        if (mem_memread) mem_read_data <= mem[mem_addr[7:0]];
    end

    function automatic vec_t mk(input string nm,
                                input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                                input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic dl,
                                input logic epg, input logic edg, input logic ewe, input logic ere,
                                input logic [31:0] ea, input logic [31:0] ewd,
                                input logic eprv, input logic [31:0] eprd,
                                input logic edrv, input logic [31:0] edrd, input logic eerr);
        vec_t v;
        v.name = nm;
        v.p_req = pr; v.p_we = pw; v.p_addr = pa; v.p_wdata = pd;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.d_lock = dl;
        v.e_p_gnt = epg; v.e_d_gnt = edg; v.e_we = ewe; v.e_re = ere;
        v.e_addr = ea; v.e_wdata = ewd;
        v.e_prv = eprv; v.e_prd = eprd; v.e_drv = edrv; v.e_drd = edrd; v.e_err = eerr;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        p_req = v.p_req; p_we = v.p_we; p_addr = v.p_addr; p_wdata = v.p_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        d_lock = v.d_lock;
    endtask

    task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, act, exp);
        end
    endtask

    task automatic checkVector(input vec_t v);
        checkOutput({v.name, ".p_gnt"}, {31'd0, p_gnt}, {31'd0, v.e_p_gnt});
        checkOutput({v.name, ".d_gnt"}, {31'd0, d_gnt}, {31'd0, v.e_d_gnt});
        checkOutput({v.name, ".p_stall"}, {31'd0, p_stall}, {31'd0, v.p_req & ~v.e_p_gnt});
        checkOutput({v.name, ".memwrite"}, {31'd0, mem_memwrite}, {31'd0, v.e_we});
        checkOutput({v.name, ".memread"}, {31'd0, mem_memread}, {31'd0, v.e_re});
        checkOutput({v.name, ".mem_addr"}, mem_addr, v.e_addr);
        checkOutput({v.name, ".mem_wdata"}, mem_write_data, v.e_wdata);
        checkOutput({v.name, ".p_rvalid"}, {31'd0, p_rvalid}, {31'd0, v.e_prv});
        if (v.e_prv) checkOutput({v.name, ".p_rdata"}, p_rdata, v.e_prd);
        checkOutput({v.name, ".d_rvalid"}, {31'd0, d_rvalid}, {31'd0, v.e_drv});
        if (v.e_drv) checkOutput({v.name, ".d_rdata"}, d_rdata, v.e_drd);
        checkOutput({v.name, ".err_addr"}, {31'd0, err_addr}, {31'd0, v.e_err});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0000_00A0 + 32'(i);

        //            name        pr pw paddr  pwdata        dr dw daddr  dwdata        dl  pg dg we re addr   wdata         prv prd           drv drd           err
        vecs[0]  = mk("idle0",    0, 0, 32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[1]  = mk("p_rd5",    1, 0, 32'd5,  32'h0,       0, 0, 32'd0,  32'h0,       0,  1, 0, 0, 1, 32'd5,  32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[2]  = mk("p_rd5_rsp",0, 0, 32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        1, 32'hA5,       0, 32'h0,        0);
        vecs[3]  = mk("p_wr_d_rd",1, 1, 32'd10, 32'h1234,    1, 0, 32'd10, 32'h0,       0,  1, 0, 1, 0, 32'd10, 32'h1234,     0, 32'h0,        0, 32'h0,        0);
        vecs[4]  = mk("d_rd10",   0, 0, 32'd0,  32'h0,       1, 0, 32'd10, 32'h0,       0,  0, 1, 0, 1, 32'd10, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[5]  = mk("d_rd10_rsp",0,0, 32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        0, 32'h0,        1, 32'h1234,     0);
        vecs[6]  = mk("d_wr300",  0, 0, 32'd0,  32'h0,       1, 1, 32'd300,32'hDEAD,    0,  0, 1, 0, 0, 32'd300,32'hDEAD,     0, 32'h0,        0, 32'h0,        0);
        vecs[7]  = mk("d_rd300",  0, 0, 32'd0,  32'h0,       1, 0, 32'd300,32'h0,       0,  0, 1, 0, 0, 32'd300,32'h0,        0, 32'h0,        0, 32'h0,        1);
        vecs[8]  = mk("d_rd300_rsp",0,0,32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        0, 32'h0,        1, 32'h0,        1);
        vecs[9]  = mk("d_rd44",   0, 0, 32'd0,  32'h0,       1, 0, 32'd44, 32'h0,       0,  0, 1, 0, 1, 32'd44, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[10] = mk("d_rd44_rsp",0,0, 32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        0, 32'h0,        1, 32'hCC,       0);
        vecs[11] = mk("p_rd255",  1, 0, 32'd255,32'h0,       0, 0, 32'd0,  32'h0,       0,  1, 0, 0, 1, 32'd255,32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[12] = mk("p_rd256",  1, 0, 32'd256,32'h0,       0, 0, 32'd0,  32'h0,       0,  1, 0, 0, 0, 32'd256,32'h0,        1, 32'h19F,      0, 32'h0,        0);
        vecs[13] = mk("p_rd256_rsp",0,0,32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        1, 32'h0,        0, 32'h0,        1);
        vecs[14] = mk("lk_wr20",  0, 0, 32'd0,  32'h0,       1, 1, 32'd20, 32'h55,      1,  0, 1, 1, 0, 32'd20, 32'h55,       0, 32'h0,        0, 32'h0,        0);
        vecs[15] = mk("lk_rd21",  1, 0, 32'd20, 32'h0,       1, 0, 32'd21, 32'h0,       1,  0, 1, 0, 1, 32'd21, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[16] = mk("lk_noreq", 1, 0, 32'd20, 32'h0,       0, 0, 32'd0,  32'h0,       1,  0, 0, 0, 0, 32'd0,  32'h0,        0, 32'h0,        1, 32'hB5,       0);
        vecs[17] = mk("lk_last",  1, 0, 32'd20, 32'h0,       1, 0, 32'd21, 32'h0,       0,  0, 1, 0, 1, 32'd21, 32'h0,        0, 32'h0,        0, 32'h0,        0);
        vecs[18] = mk("unlock_p", 1, 0, 32'd20, 32'h0,       0, 0, 32'd0,  32'h0,       0,  1, 0, 0, 1, 32'd20, 32'h0,        0, 32'h0,        1, 32'hB5,       0);
        vecs[19] = mk("unlock_rsp",0,0, 32'd0,  32'h0,       0, 0, 32'd0,  32'h0,       0,  0, 0, 0, 0, 32'd0,  32'h0,        1, 32'h55,       0, 32'h0,        0);

        // Reset values, with a pending request that must not be granted.
        rst_n = 1'b0;
        applyStimulus(vecs[0]);
        p_req = 1'b1; p_addr = 32'd5;
        d_req = 1'b1; d_addr = 32'd6;
        #2;
        checkOutput("rst.p_gnt", {31'd0, p_gnt}, 32'd0);
        checkOutput("rst.d_gnt", {31'd0, d_gnt}, 32'd0);
        checkOutput("rst.memread", {31'd0, mem_memread}, 32'd0);
        checkOutput("rst.p_rvalid", {31'd0, p_rvalid}, 32'd0);
        checkOutput("rst.d_rvalid", {31'd0, d_rvalid}, 32'd0);
        checkOutput("rst.p_rdata", p_rdata, 32'd0);
        checkOutput("rst.d_rdata", d_rdata, 32'd0);
        checkOutput("rst.err_addr", {31'd0, err_addr}, 32'd0);
        applyStimulus(vecs[0]);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: one row per cycle, drive 1 after posedge, sample 2 after posedge.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 applyStimulus(vecs[i]);
            #1 checkVector(vecs[i]);
        end

        // Starvation: both request every cycle; D must win exactly on the 5th cycle.
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'd1; p_wdata = 32'h0;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'd2; d_wdata = 32'h0; d_lock = 1'b0;
            #1;
            checkOutput($sformatf("starve%0d.p_gnt", c), {31'd0, p_gnt}, (c == 5) ? 32'd0 : 32'd1);
            checkOutput($sformatf("starve%0d.d_gnt", c), {31'd0, d_gnt}, (c == 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("starve%0d.p_stall", c), {31'd0, p_stall}, (c == 5) ? 32'd1 : 32'd0);
            checkOutput($sformatf("starve%0d.mem_addr", c), mem_addr, (c == 5) ? 32'd2 : 32'd1);
        end
        @(posedge clk);
        #1 applyStimulus(vecs[0]);

        // Reset in the middle of a pending response and error pulse.
        @(posedge clk);
        #1;
        p_req = 1'b1; p_we = 1'b0; p_addr = 32'd400;
        #1 checkOutput("rstmid.oob_gnt", {31'd0, p_gnt}, 32'd1);
        @(posedge clk);
        #1;
        p_addr = 32'd5;
        d_req = 1'b1; d_addr = 32'd3;
        #1;
        checkOutput("rstmid.pre_rvalid", {31'd0, p_rvalid}, 32'd1);
        checkOutput("rstmid.pre_err", {31'd0, err_addr}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid.p_rvalid", {31'd0, p_rvalid}, 32'd0);
        checkOutput("rstmid.err_addr", {31'd0, err_addr}, 32'd0);
        checkOutput("rstmid.p_gnt", {31'd0, p_gnt}, 32'd0);
        checkOutput("rstmid.d_gnt", {31'd0, d_gnt}, 32'd0);
        checkOutput("rstmid.memread", {31'd0, mem_memread}, 32'd0);
        checkOutput("rstmid.memwrite", {31'd0, mem_memwrite}, 32'd0);
        checkOutput("rstmid.mem_addr", mem_addr, 32'd0);
        checkOutput("rstmid.p_stall", {31'd0, p_stall}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstmid.post_p_gnt", {31'd0, p_gnt}, 32'd1);
        checkOutput("rstmid.post_d_gnt", {31'd0, d_gnt}, 32'd0);
        applyStimulus(vecs[0]);
        @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
